axil_csr_slave: RTL and testbench

//  Self-contained AXI4-Lite slave with a built-in CSR array of NUM_REGS words. Per-register

---
 rtl/axil_csr_pkg.sv | 39 +++
 rtl/axil_csr_if.sv | 33 +++
 rtl/axil_txn_timer.sv | 28 ++
 rtl/axil_csr_slave.sv | 208 ++++++++++++++++++++
 tb/tb_axil_csr_slave.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_csr_pkg.sv
// rtl/axil_csr_pkg.sv - shared types and helpers for the AXI-Lite CSR slave
package axil_csr_pkg;

  // Widest data bus the byte-merge helper supports; narrower buses zero-extend.
  localparam int MAX_DATA_W = 128;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wr_st_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_st_t;

  // Replace each byte of old_word whose strobe bit is set with the matching byte of new_word.
  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_csr_if.sv
// rtl/axil_csr_if.sv - AXI4-Lite bus bundle with master and slave views
interface axil_csr_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_txn_timer.sv
// rtl/axil_txn_timer.sv - cycle counter flagging an unpaired write half that waited too long
module axil_txn_timer #(
  parameter int TXN_TIMEOUT = 50
) (
  input  logic clk,
  input  logic arst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int CNT_W = $clog2(TXN_TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // expired fires on the TXN_TIMEOUT-th consecutive enabled cycle
  assign expired = en & (r_cnt == CNT_W'(TXN_TIMEOUT - 1));

  // Count enabled cycles, saturating at the limit; clr restarts from zero.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/axil_csr_slave.sv
// rtl/axil_csr_slave.sv - AXI4-Lite slave with a permissioned CSR array
module axil_csr_slave
  import axil_csr_pkg::*;
#(
  parameter int                   DATA_W      = 32,
  parameter int                   ADDR_W      = 8,
  parameter int                   NUM_REGS    = 16,
  parameter logic [2*NUM_REGS-1:0] REG_ACCESS = '1,
  parameter int                   TXN_TIMEOUT = 50
) (
  input  logic                         clk,
  input  logic                         arst_n,
  axil_csr_if.slave                    s,
  output logic [NUM_REGS*DATA_W-1:0]   csr_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);
  localparam int STRB_W = DATA_W / 8;
  localparam int AW_LSB = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - AW_LSB;

  wr_st_t              r_wst;
  rd_st_t              r_rst;
  logic [DATA_W-1:0]   r_csr [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;

  logic                r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
  logic [IDX_W-1:0]    r_aw_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  axi_resp_t           r_bresp;

  logic                r_arready, r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  axi_resp_t           r_rresp;

  logic                w_aw_hs, w_w_hs, w_ar_hs;
  logic [IDX_W-1:0]    w_ar_idx;
  axi_resp_t           w_wr_resp, w_rd_resp;
  logic [NUM_REGS-1:0] w_wr_sel;
  logic [DATA_W-1:0]   w_wr_word, w_rd_word, w_merged;
  logic                w_tmr_en, w_tmr_clr, w_tmr_expired;
  logic                w_unused_addr;

  assign s.awready = r_awready;
  assign s.wready  = r_wready;
  assign s.bvalid  = r_bvalid;
  assign s.bresp   = r_bresp;
  assign s.arready = r_arready;
  assign s.rvalid  = r_rvalid;
  assign s.rresp   = r_rresp;
  assign s.rdata   = r_rdata;
  assign wr_pulse  = r_wr_pulse;

  assign w_aw_hs  = s.awvalid & r_awready & (r_wst == W_IDLE);
  assign w_w_hs   = s.wvalid & r_wready & (r_wst == W_IDLE);
  assign w_ar_hs  = s.arvalid & r_arready & (r_rst == R_IDLE);
  assign w_ar_idx = s.araddr[ADDR_W-1:AW_LSB];
  // Sub-word address bits carry no meaning for word-wide registers.
  assign w_unused_addr = ^{s.awaddr, s.araddr};

  // The timer only runs while exactly one half of a write is parked.
  assign w_tmr_en  = (r_wst == W_IDLE) & (r_aw_held ^ r_w_held);
  assign w_tmr_clr = ~w_tmr_en;

  axil_txn_timer #(
    .TXN_TIMEOUT (TXN_TIMEOUT)
  ) u_txn_timer (
    .clk     (clk),
    .arst_n  (arst_n),
    .en      (w_tmr_en),
    .clr     (w_tmr_clr),
    .expired (w_tmr_expired)
  );

  // Flatten the register array onto the csr_q bus.
  always_comb begin
    csr_q = '0;
    for (int i = 0; i < NUM_REGS; i++) csr_q[i*DATA_W +: DATA_W] = r_csr[i];
  end

  // Decode the held write index: select line, old word, and response.
  always_comb begin
    w_wr_resp = DECERR;
    w_wr_sel  = '0;
    w_wr_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_aw_idx == IDX_W'(i)) begin
        w_wr_sel[i] = 1'b1;
        w_wr_word   = r_csr[i];
        w_wr_resp   = REG_ACCESS[2*i] ? OKAY : SLVERR;
      end
    end
    w_merged = DATA_W'(strb_merge(MAX_DATA_W'(w_wr_word), MAX_DATA_W'(r_wdata),
                                  MAX_STRB_W'(r_wstrb)));
  end

  // Decode the live read address: response and current register word.
  always_comb begin
    w_rd_resp = DECERR;
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDX_W'(i)) begin
        w_rd_word = r_csr[i];
        w_rd_resp = REG_ACCESS[2*i+1] ? OKAY : SLVERR;
      end
    end
  end

  // Write FSM: collect AW and W in any order, commit once, then hold B until accepted.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wst      <= W_IDLE;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= OKAY;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_csr[i] <= '0;
    end else begin
      r_wr_pulse <= '0;
      case (r_wst)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_idx  <= s.awaddr[ADDR_W-1:AW_LSB];
            r_aw_held <= 1'b1;
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata  <= s.wdata;
            r_wstrb  <= s.wstrb;
            r_w_held <= 1'b1;
            r_wready <= 1'b0;
          end
          if ((r_aw_held | w_aw_hs) && (r_w_held | w_w_hs)) begin
            r_wst <= W_COMMIT;
          end else if (w_tmr_expired) begin
            // Orphaned half is dropped; the master gets SLVERR for it.
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bresp   <= SLVERR;
            r_bvalid  <= 1'b1;
            r_wst     <= W_RESP;
          end
        end
        W_COMMIT: begin
          r_aw_held <= 1'b0;
          r_w_held  <= 1'b0;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_sel[i] && (w_wr_resp == OKAY)) begin
              r_csr[i]      <= w_merged;
              r_wr_pulse[i] <= |r_wstrb;
            end
          end
          r_bresp  <= w_wr_resp;
          r_bvalid <= 1'b1;
          r_wst    <= W_RESP;
        end
        W_RESP: begin
          if (s.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wst     <= W_IDLE;
          end
        end
        default: r_wst <= W_IDLE;
      endcase
    end
  end

  // Read FSM: register data on AR handshake, hold it until R is accepted.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rst     <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rresp   <= OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rst)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rresp   <= w_rd_resp;
            r_rdata   <= (w_rd_resp == OKAY) ? w_rd_word : '0;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rst     <= R_DATA;
          end
        end
        R_DATA: begin
          if (s.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rst     <= R_IDLE;
          end
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_csr_slave.sv
// tb/tb_axil_csr_slave.sv - directed self-checking bench for axil_csr_slave
module tb_axil_csr_slave;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [NREG*32-1:0] csr_q;
  logic [NREG-1:0]    wr_pulse;
  logic [NREG-1:0]    pulse_acc;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axil_csr_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  // reg 5 not writable, reg 6 not readable
  axil_csr_slave #(
    .DATA_W(32), .ADDR_W(8), .NUM_REGS(NREG),
    .REG_ACCESS(32'hFFFF_DBFF), .TXN_TIMEOUT(50)
  ) dut (
    .clk(clk), .arst_n(arst_n), .s(bus.slave), .csr_q(csr_q), .wr_pulse(wr_pulse)
  );

  always @(negedge clk) pulse_acc <= pulse_acc | wr_pulse;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return csr_q[i*32 +: 32];
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                          output logic [1:0] resp);
    int n;
    bit aw_done, w_done, hs_aw, hs_w;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = st; bus.wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      tick(); n++;
      if (hs_aw) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  bus.wvalid = 1'b0; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    if (!bus.bvalid) begin
      resp = 2'bxx;
    end else begin
      resp = bus.bresp;
      bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat);
    int n;
    bus.araddr = a; bus.arvalid = 1'b1; n = 0;
    while (!bus.arready && n < 20) begin tick(); n++; end
    tick(); bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 20) begin tick(); lat++; end
    if (!bus.rvalid) begin
      d = 'x; resp = 2'bxx;
    end else begin
      d = bus.rdata; resp = bus.rresp;
      bus.rready = 1'b1; tick(); bus.rready = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      $display("FAIL %s_ready: got %b expected 111", tag, {bus.awready, bus.wready, bus.arready}); n_fail++; end
    n_tests++; if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0) begin
      $display("FAIL %s_valid_resp: got %b expected 000000", tag, {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}); n_fail++; end
    n_tests++; if (bus.rdata !== 32'h0) begin
      $display("FAIL %s_rdata: got %h expected 0", tag, bus.rdata); n_fail++; end
    n_tests++; if (csr_q !== '0) begin
      $display("FAIL %s_csr_q: got nonzero %h expected 0", tag, csr_q); n_fail++; end
    n_tests++; if (wr_pulse !== '0) begin
      $display("FAIL %s_wr_pulse: got %h expected 0", tag, wr_pulse); n_fail++; end
  endtask

  task automatic test_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; int lat;
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick(); bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n_tests++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b000) begin
      $display("FAIL basic_commit_cycle: got %b expected 000", {bus.bvalid, bus.awready, bus.wready}); n_fail++; end
    tick();
    n_tests++; if ({bus.bvalid, bus.bresp} !== 3'b100) begin
      $display("FAIL basic_bvalid: got %b expected 100", {bus.bvalid, bus.bresp}); n_fail++; end
    n_tests++; if (wr_pulse !== 16'h0002) begin
      $display("FAIL basic_wr_pulse: got %h expected 0002", wr_pulse); n_fail++; end
    n_tests++; if (reg_of(1) !== 32'hDEADBEEF) begin
      $display("FAIL basic_csr1: got %h expected deadbeef", reg_of(1)); n_fail++; end
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    n_tests++; if ({bus.bvalid, wr_pulse, bus.awready, bus.wready} !== {1'b0, 16'h0, 2'b11}) begin
      $display("FAIL basic_after_b: got %b expected 0/0000/11", {bus.bvalid, wr_pulse, bus.awready, bus.wready}); n_fail++; end
    do_read(8'h04, d, r, lat);
    n_tests++; if ({d, r} !== {32'hDEADBEEF, 2'b00}) begin
      $display("FAIL basic_read: got %h/%b expected deadbeef/00", d, r); n_fail++; end
    n_tests++; if (lat !== 0) begin
      $display("FAIL basic_read_latency: got %0d extra cycles expected 0", lat); n_fail++; end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(8'h08, 32'h11223344, 4'hF, r);
    do_write(8'h08, 32'hAABBCCDD, 4'h5, r);
    n_tests++; if (r !== 2'b00) begin
      $display("FAIL strobe_bresp: got %b expected 00", r); n_fail++; end
    do_read(8'h08, d, r, lat);
    n_tests++; if (d !== 32'h11BB33DD) begin
      $display("FAIL strobe_merge: got %h expected 11bb33dd", d); n_fail++; end
    pulse_acc = '0;
    do_write(8'h08, 32'h99999999, 4'h0, r);
    n_tests++; if ({r, pulse_acc, reg_of(2)} !== {2'b00, 16'h0, 32'h11BB33DD}) begin
      $display("FAIL strobe_zero: got %b/%h/%h expected 00/0000/11bb33dd", r, pulse_acc, reg_of(2)); n_fail++; end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r; int lat;
    pulse_acc = '0;
    do_write(8'h14, 32'h5A5A5A5A, 4'hF, r);
    n_tests++; if ({r, reg_of(5), pulse_acc} !== {2'b10, 32'h0, 16'h0}) begin
      $display("FAIL err_ro_write: got %b/%h/%h expected 10/00000000/0000", r, reg_of(5), pulse_acc); n_fail++; end
    do_read(8'h40, d, r, lat);
    n_tests++; if ({r, d} !== {2'b11, 32'h0}) begin
      $display("FAIL err_decerr_read: got %b/%h expected 11/00000000", r, d); n_fail++; end
    do_write(8'h40, 32'h1, 4'hF, r);
    n_tests++; if (r !== 2'b11) begin
      $display("FAIL err_decerr_write: got %b expected 11", r); n_fail++; end
    do_write(8'h18, 32'hCAFEF00D, 4'hF, r);
    do_read(8'h18, d, r, lat);
    n_tests++; if ({r, d, reg_of(6)} !== {2'b10, 32'h0, 32'hCAFEF00D}) begin
      $display("FAIL err_wo_read: got %b/%h/%h expected 10/00000000/cafef00d", r, d, reg_of(6)); n_fail++; end
  endtask

  task automatic test_timeout();
    int n;
    pulse_acc = '0;
    bus.wdata = 32'h55555555; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick(); bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 80) begin tick(); n++; end
    n_tests++; if (n !== 50) begin
      $display("FAIL timeout_cycles: got %0d expected 50", n); n_fail++; end
    n_tests++; if ({bus.bvalid, bus.bresp, pulse_acc} !== {1'b1, 2'b10, 16'h0}) begin
      $display("FAIL timeout_resp: got %b/%b/%h expected 1/10/0000", bus.bvalid, bus.bresp, pulse_acc); n_fail++; end
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
    tick(); bus.awvalid = 1'b0;
    tick(); tick(); tick();
    n_tests++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b001) begin
      $display("FAIL timeout_aw_parked: got %b expected 001", {bus.bvalid, bus.awready, bus.wready}); n_fail++; end
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick(); bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    n_tests++; if ({bus.bvalid, bus.bresp, reg_of(3)} !== {1'b1, 2'b00, 32'h12345678}) begin
      $display("FAIL timeout_fresh_pair: got %b/%b/%h expected 1/00/12345678", bus.bvalid, bus.bresp, reg_of(3)); n_fail++; end
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    bus.wdata = 32'h0BADCAFE; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick(); bus.wvalid = 1'b0;
    tick(); tick();
    bus.awaddr = 8'h10; bus.awvalid = 1'b1;
    tick(); bus.awvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    for (int c = 0; c < 10; c++) begin
      n_tests++; if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin
        $display("FAIL b2b_hold_c%0d: got %b expected 10000", c, {bus.bvalid, bus.bresp, bus.awready, bus.wready}); n_fail++; end
      tick();
    end
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    n_tests++; if ({bus.bvalid, bus.awready, bus.wready, reg_of(4)} !== {3'b011, 32'h0BADCAFE}) begin
      $display("FAIL b2b_release: got %b/%h expected 011/0badcafe", {bus.bvalid, bus.awready, bus.wready}, reg_of(4)); n_fail++; end
  endtask

  task automatic test_simultaneous();
    bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'hFFFF0000; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick(); bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 8'h0C; bus.arvalid = 1'b1;
    tick(); bus.arvalid = 1'b0;
    n_tests++; if ({bus.rvalid, bus.rresp, bus.rdata} !== {1'b1, 2'b00, 32'h12345678}) begin
      $display("FAIL simul_old_value: got %b/%b/%h expected 1/00/12345678", bus.rvalid, bus.rresp, bus.rdata); n_fail++; end
    n_tests++; if ({bus.bvalid, reg_of(3), wr_pulse} !== {1'b1, 32'hFFFF0000, 16'h0008}) begin
      $display("FAIL simul_commit: got %b/%h/%h expected 1/ffff0000/0008", bus.bvalid, reg_of(3), wr_pulse); n_fail++; end
    bus.bready = 1'b1; bus.rready = 1'b1; tick(); bus.bready = 1'b0; bus.rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat;
    bus.awaddr = 8'h1C; bus.awvalid = 1'b1;
    bus.araddr = 8'h04; bus.arvalid = 1'b1;
    tick(); bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    arst_n = 1'b0; #1;
    check_reset_outputs("midreset");
    @(negedge clk); arst_n = 1'b1;
    tick();
    do_write(8'h1C, 32'h76543210, 4'hF, r);
    do_read(8'h1C, d, r, lat);
    n_tests++; if ({r, d} !== {2'b00, 32'h76543210}) begin
      $display("FAIL midreset_recover: got %b/%h expected 00/76543210", r, d); n_fail++; end
  endtask

  initial begin
    idle_inputs();
    pulse_acc = '0;
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); arst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_strobe();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
